traffic_gate_ctrl: RTL and testbench



---
 rtl/traffic_gate_pkg.sv | 39 +++
 rtl/traffic_gate_if.sv | 21 ++
 rtl/traffic_gate_ctrl_servo_pwm.sv | 45 ++++
 rtl/traffic_gate_ctrl.sv | 144 ++++++++++++++
 tb/tb_traffic_gate_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_gate_pkg.sv
// Shared types and 7-segment helpers for the traffic light / barrier gate controller.
package traffic_gate_pkg;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_EMERG  = 2'd3
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        case (val)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/traffic_gate_if.sv
// Pedestrian/emergency inputs and lamp/gate/display outputs of the controller.
interface traffic_gate_if;
    logic       ped_req;
    logic       emergency;
    logic       led_r;
    logic       led_y;
    logic       led_g;
    logic       pwm_out;
    logic [6:0] seg;
    logic       gate_open;

    modport master (
        output ped_req, emergency,
        input  led_r, led_y, led_g, pwm_out, seg, gate_open
    );

    modport slave (
        input  ped_req, emergency,
        output led_r, led_y, led_g, pwm_out, seg, gate_open
    );
endinterface

// File: rtl/traffic_gate_ctrl_servo_pwm.sv
// Servo PWM: fixed-length frames, pulse width only reloaded at frame start.
module servo_pwm #(
    parameter int unsigned PERIOD = 200_000,
    parameter int unsigned OPEN   = 20_000,
    parameter int unsigned CLOSED = 10_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic open_req,
    output logic pwm_out
);
    localparam int unsigned CW = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] W_OPEN   = CW'(OPEN);
    localparam logic [CW-1:0] W_CLOSED = CW'(CLOSED);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] width_q, width_d;
    logic          pwm_q, pwm_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        width_d = width_q;
        // Width only changes together with the wrap, so a frame never mixes two widths
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            width_d = open_req ? W_OPEN : W_CLOSED;
        end
        pwm_d = (cnt_q < width_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            width_q <= W_CLOSED;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
endmodule

// File: rtl/traffic_gate_ctrl.sv
// Traffic light sequencer with pedestrian shortening, emergency all-stop and servo gate.
//   state     | meaning
//   ST_RED    | stop, gate closed, counts T_RED ticks
//   ST_GREEN  | go, gate open, counts T_GREEN ticks (cut to PED_GREEN on request)
//   ST_YELLOW | clearing, gate open, counts T_YELLOW ticks
//   ST_EMERG  | all-stop while emergency is held, display 0
module traffic_gate_ctrl #(
    parameter int unsigned TICK_DIV   = 10_000_000,
    parameter int unsigned T_GREEN    = 9,
    parameter int unsigned T_YELLOW   = 3,
    parameter int unsigned T_RED      = 9,
    parameter int unsigned PED_GREEN  = 2,
    parameter int unsigned PWM_PERIOD = 200_000,
    parameter int unsigned PWM_OPEN   = 20_000,
    parameter int unsigned PWM_CLOSED = 10_000
) (
    input  logic           clk,
    input  logic           rst_n,
    traffic_gate_if.slave  bus
);
    import traffic_gate_pkg::*;

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be at least 2");
    end
    if (T_GREEN < 1 || T_GREEN > 9 || T_YELLOW < 1 || T_YELLOW > 9 || T_RED < 1 || T_RED > 9)
    begin : g_bad_dur
        $error("phase durations must be within 1..9");
    end
    if (PED_GREEN < 1 || PED_GREEN > T_GREEN) begin : g_bad_ped
        $error("PED_GREEN must be within 1..T_GREEN");
    end
    if (PWM_OPEN >= PWM_PERIOD || PWM_CLOSED >= PWM_PERIOD) begin : g_bad_pwm
        $error("PWM widths must be below PWM_PERIOD");
    end

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] REM_GREEN  = 4'(T_GREEN);
    localparam logic [3:0] REM_YELLOW = 4'(T_YELLOW);
    localparam logic [3:0] REM_RED    = 4'(T_RED);
    localparam logic [3:0] REM_PED    = 4'(PED_GREEN);

    logic ped_s1_q, ped_s2_q, ped_prev_q, emg_s1_q, emg_s2_q;
    state_t state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic [PW-1:0] presc_q, presc_d;
    logic ped_pend_q, ped_pend_d;
    logic led_r_q, led_r_d, led_y_q, led_y_d, led_g_q, led_g_d, gate_q, gate_d;
    logic [6:0] seg_q, seg_d;
    logic tick, ped_rise;

    always_comb begin
        ped_rise   = ped_s2_q & ~ped_prev_q;
        tick       = (presc_q == PRESC_LAST);
        state_d    = state_q;
        rem_d      = rem_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        ped_pend_d = ped_pend_q | ped_rise;

        if (emg_s2_q) begin
            state_d = ST_EMERG;
            rem_d   = '0;
            presc_d = '0;
        end else if (state_q == ST_EMERG) begin
            state_d = ST_RED;
            rem_d   = REM_RED;
            presc_d = '0;
        end else begin
            if (tick && rem_q == 4'd1) begin
                presc_d = '0;
                case (state_q)
                    ST_RED:    begin state_d = ST_GREEN;  rem_d = REM_GREEN;  end
                    ST_GREEN:  begin state_d = ST_YELLOW; rem_d = REM_YELLOW; end
                    default:   begin state_d = ST_RED;    rem_d = REM_RED;    end
                endcase
            end else if (tick) begin
                rem_d = rem_q - 4'd1;
            end
            // A fresh edge is served directly so the cut lands three edges after the press
            if (state_q == ST_GREEN && (ped_pend_q || ped_rise)) begin
                ped_pend_d = 1'b0;
                if (rem_q > REM_PED) rem_d = REM_PED;
            end
        end

        led_r_d = (state_d == ST_RED) || (state_d == ST_EMERG);
        led_y_d = (state_d == ST_YELLOW);
        led_g_d = (state_d == ST_GREEN);
        gate_d  = (state_d == ST_GREEN) || (state_d == ST_YELLOW);
        seg_d   = seg_decode(rem_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_s1_q   <= 1'b0;
            ped_s2_q   <= 1'b0;
            ped_prev_q <= 1'b0;
            emg_s1_q   <= 1'b0;
            emg_s2_q   <= 1'b0;
            state_q    <= ST_RED;
            rem_q      <= REM_RED;
            presc_q    <= '0;
            ped_pend_q <= 1'b0;
            led_r_q    <= 1'b1;
            led_y_q    <= 1'b0;
            led_g_q    <= 1'b0;
            gate_q     <= 1'b0;
            seg_q      <= seg_decode(REM_RED);
        end else begin
            ped_s1_q   <= bus.ped_req;
            ped_s2_q   <= ped_s1_q;
            ped_prev_q <= ped_s2_q;
            emg_s1_q   <= bus.emergency;
            emg_s2_q   <= emg_s1_q;
            state_q    <= state_d;
            rem_q      <= rem_d;
            presc_q    <= presc_d;
            ped_pend_q <= ped_pend_d;
            led_r_q    <= led_r_d;
            led_y_q    <= led_y_d;
            led_g_q    <= led_g_d;
            gate_q     <= gate_d;
            seg_q      <= seg_d;
        end
    end

    servo_pwm #(
        .PERIOD (PWM_PERIOD),
        .OPEN   (PWM_OPEN),
        .CLOSED (PWM_CLOSED)
    ) u_servo_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .open_req (gate_q),
        .pwm_out  (bus.pwm_out)
    );

    assign bus.led_r     = led_r_q;
    assign bus.led_y     = led_y_q;
    assign bus.led_g     = led_g_q;
    assign bus.gate_open = gate_q;
    assign bus.seg       = seg_q;
endmodule

// File: tb/tb_traffic_gate_ctrl.sv
// Directed bench for traffic_gate_ctrl with short timing parameters.
module tb_traffic_gate_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int k = 0;
    int n_pass = 0;
    int n_total = 0;

    traffic_gate_if tif();

    traffic_gate_ctrl #(
        .TICK_DIV(4), .T_GREEN(5), .T_YELLOW(2), .T_RED(3), .PED_GREEN(2),
        .PWM_PERIOD(10), .PWM_OPEN(3), .PWM_CLOSED(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dig(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Idle-run timeline: RED 0..11, GREEN 12..31, YELLOW 32..39, RED 40..51, GREEN 52..
    function automatic int exp_phase(input int t);
        if (t < 12) return 0;
        if (t < 32) return 1;
        if (t < 40) return 2;
        if (t < 52) return 0;
        return 1;
    endfunction

    function automatic int exp_rem(input int t);
        if (t < 12) return 3 - t / 4;
        if (t < 32) return 5 - (t - 12) / 4;
        if (t < 40) return 2 - (t - 32) / 4;
        if (t < 52) return 3 - (t - 40) / 4;
        return 5 - (t - 52) / 4;
    endfunction

    function automatic logic exp_pwm(input int t);
        int j;
        int w;
        j = t - 1;
        w = (j < 20) ? 1 : ((j < 50) ? 3 : 1);
        return (j % 10) < w;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    endtask

    task automatic step_to(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_led_r"}, tif.led_r, 1'b1);
        chk1({tag, "_led_y"}, tif.led_y, 1'b0);
        chk1({tag, "_led_g"}, tif.led_g, 1'b0);
        chk1({tag, "_gate"}, tif.gate_open, 1'b0);
        chk1({tag, "_pwm"}, tif.pwm_out, 1'b0);
        chk7({tag, "_seg"}, tif.seg, dig(3));
    endtask

    initial begin
        tif.ped_req   = 1'b0;
        tif.emergency = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        k = 0;

        // Idle sequencing, lamp/seg/pwm every cycle
        for (int t = 1; t <= 55; t++) begin
            step_to(t);
            chk1("idle_led_r", tif.led_r, exp_phase(t) == 0);
            chk1("idle_led_g", tif.led_g, exp_phase(t) == 1);
            chk1("idle_led_y", tif.led_y, exp_phase(t) == 2);
            chk1("idle_gate", tif.gate_open, exp_phase(t) != 0);
            chk7("idle_seg", tif.seg, dig(exp_rem(t - 1)));
            chk1("idle_pwm", tif.pwm_out, exp_pwm(t));
        end

        // Pedestrian press at GREEN remaining=5
        do_reset();
        step_to(12);
        chk1("ped_green_entry", tif.led_g, 1'b1);
        tif.ped_req = 1'b1;
        step_to(15);
        tif.ped_req = 1'b0;
        chk7("ped_before_cut", tif.seg, dig(5));
        step_to(16);
        chk7("ped_cut_to_2", tif.seg, dig(2));
        step_to(17);
        chk7("ped_tick_to_1", tif.seg, dig(1));
        step_to(19);
        chk1("ped_still_green", tif.led_g, 1'b1);
        step_to(20);
        chk1("ped_yellow", tif.led_y, 1'b1);
        chk1("ped_green_off", tif.led_g, 1'b0);

        // Press during RED is held until GREEN
        step_to(29);
        tif.ped_req = 1'b1;
        step_to(31);
        tif.ped_req = 1'b0;
        step_to(39);
        chk1("held_red", tif.led_r, 1'b1);
        step_to(40);
        chk1("held_green_entry", tif.led_g, 1'b1);
        step_to(41);
        chk7("held_loads_5", tif.seg, dig(5));
        step_to(42);
        chk7("held_served_2", tif.seg, dig(2));
        step_to(47);
        chk1("held_green_end", tif.led_g, 1'b1);
        step_to(48);
        chk1("held_yellow", tif.led_y, 1'b1);

        // Press at GREEN remaining=1: no change, pending dropped
        step_to(83);
        tif.ped_req = 1'b1;
        step_to(85);
        tif.ped_req = 1'b0;
        step_to(87);
        chk1("one_still_green", tif.led_g, 1'b1);
        step_to(88);
        chk1("one_yellow", tif.led_y, 1'b1);
        step_to(108);
        chk1("one_next_green", tif.led_g, 1'b1);
        step_to(109);
        chk7("one_next_seg5", tif.seg, dig(5));
        step_to(110);
        chk7("one_pending_cleared", tif.seg, dig(5));

        // Emergency during GREEN
        do_reset();
        step_to(14);
        tif.emergency = 1'b1;
        step_to(16);
        chk1("emg_pre_green", tif.led_g, 1'b1);
        chk1("emg_pre_gate", tif.gate_open, 1'b1);
        step_to(17);
        chk1("emg_led_r", tif.led_r, 1'b1);
        chk1("emg_led_g", tif.led_g, 1'b0);
        chk1("emg_gate", tif.gate_open, 1'b0);
        step_to(18);
        chk7("emg_seg0", tif.seg, dig(0));
        step_to(22);
        tif.emergency = 1'b0;
        step_to(24);
        chk1("emg_hold_r", tif.led_r, 1'b1);
        chk7("emg_hold_seg0", tif.seg, dig(0));
        step_to(25);
        chk1("emg_exit_red", tif.led_r, 1'b1);
        step_to(26);
        chk7("emg_exit_seg3", tif.seg, dig(3));
        step_to(36);
        chk1("emg_red_last", tif.led_r, 1'b1);
        step_to(37);
        chk1("emg_red_12_green", tif.led_g, 1'b1);
        chk1("emg_red_12_r", tif.led_r, 1'b0);

        // Asynchronous reset mid-YELLOW, between edges
        do_reset();
        step_to(33);
        chk1("ar_pre_yellow", tif.led_y, 1'b1);
        chk1("ar_pre_pwm", tif.pwm_out, 1'b1);
        chk7("ar_pre_seg", tif.seg, dig(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
